// File: rtl/dm_read_cache.sv
// dm_read_cache: direct-mapped, read-only byte cache in front of a word RAM.
// Eight lines, each with a valid bit, a 4-bit tag and a 32-bit word.
// Processor addresses are 9-bit byte addresses split as [8:5] tag,
// [4:2] index and [1:0] byte offset. A hit answers one cycle after the request.
// A miss fetches the word from RAM, installs it in the line and answers
// MEM_LATENCY+2 cycles after the request.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req          read request, only looked at while idle
//   p_address    processor byte address
//   flush        invalidate every line (deferred until idle if busy)
//   mem_din      word returned by RAM, MEM_LATENCY cycles after mem_rd
//   mem_address  RAM word address of the outstanding miss
//   mem_rd       one-cycle RAM read strobe
//   dout         byte returned to processor, held until the next dv
//   dv           one-cycle data-valid pulse
//   busy         high whenever the controller is not idle
//   hit_cnt      saturating count of accepted hits
//   miss_cnt     saturating count of accepted misses
module dm_read_cache #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [8:0]  p_address,
  input  logic        flush,
  input  logic [31:0] mem_din,
  output logic [6:0]  mem_address,
  output logic        mem_rd,
  output logic [7:0]  dout,
  output logic        dv,
  output logic        busy,
  output logic [7:0]  hit_cnt,
  output logic [7:0]  miss_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL_REQ  = 2'd1,
    FILL_WAIT = 2'd2,
    RESP      = 2'd3
  } state_t;

  // FILL_WAIT lasts MEM_LATENCY cycles; mem_din is captured on the last one.
  localparam logic [2:0] LAST_WAIT = 3'(MEM_LATENCY - 1);

  function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] off);
    case (off)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_valid;
  logic [3:0]  r_tag  [8];
  logic [31:0] r_data [8];
  logic [8:0]  r_req_addr;
  logic [2:0]  r_wait_cnt;
  logic        r_flush_pend;
  logic [7:0]  r_dout;
  logic [7:0]  r_hit_cnt;
  logic [7:0]  r_miss_cnt;

  logic [2:0]  w_idx;
  logic [2:0]  w_fill_idx;
  logic        w_hit;
  logic        w_flush_now;
  logic        w_accept;
  logic        w_fill_done;

  assign w_idx      = p_address[4:2];
  assign w_fill_idx = r_req_addr[4:2];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == p_address[8:5]);
  // A flush deferred from a busy period is applied on the first idle cycle
  // and, like a live flush, wins over a request in that cycle.
  assign w_flush_now = (r_state == IDLE) && (flush || r_flush_pend);
  assign w_accept    = (r_state == IDLE) && req && !w_flush_now;
  assign w_fill_done = (r_state == FILL_WAIT) && (r_wait_cnt == LAST_WAIT);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_accept) w_next = w_hit ? RESP : FILL_REQ;
      FILL_REQ:  w_next = FILL_WAIT;
      FILL_WAIT: if (w_fill_done) w_next = RESP;
      RESP:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments only, so every register
  // samples the values from before the edge regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_valid      <= '0;
      r_req_addr   <= '0;
      r_wait_cnt   <= '0;
      r_flush_pend <= 1'b0;
      r_dout       <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      r_state <= w_next;

      if (r_state == IDLE)  r_flush_pend <= 1'b0;
      else if (flush)       r_flush_pend <= 1'b1;

      if (w_flush_now)      r_valid             <= '0;
      else if (w_fill_done) r_valid[w_fill_idx] <= 1'b1;

      if (r_state == FILL_WAIT) r_wait_cnt <= r_wait_cnt + 3'd1;
      else                      r_wait_cnt <= '0;

      if (w_accept && !w_hit) r_req_addr <= p_address;

      if (w_accept && w_hit) r_dout <= sel_byte(r_data[w_idx], p_address[1:0]);
      else if (w_fill_done)  r_dout <= sel_byte(mem_din, r_req_addr[1:0]);

      if (w_accept && w_hit && (r_hit_cnt != 8'hFF))   r_hit_cnt  <= r_hit_cnt + 8'd1;
      if (w_accept && !w_hit && (r_miss_cnt != 8'hFF)) r_miss_cnt <= r_miss_cnt + 8'd1;
    end
  end

  // NOTE: tag and data arrays carry no reset; a line's contents are only
  // ever read while its valid bit is set, and valid bits are reset.
  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_tag[w_fill_idx]  <= r_req_addr[8:5];
      r_data[w_fill_idx] <= mem_din;
    end
  end

  assign mem_address = r_req_addr[8:2];
  assign mem_rd      = (r_state == FILL_REQ);
  assign dv          = (r_state == RESP);
  assign busy        = (r_state != IDLE);
  assign dout        = r_dout;
  assign hit_cnt     = r_hit_cnt;
  assign miss_cnt    = r_miss_cnt;

endmodule

// File: tb/tb_dm_read_cache.sv
// Self-checking bench for dm_read_cache. A transaction-level model tracks
// line contents, counters and, for each accepted request, the cycle numbers
// at which mem_rd, dv and the end of busy must appear. Every cycle the DUT
// outputs are compared with those expectations; directed sequences add
// literal expectations for latency, returned bytes and counters.
module tb_dm_read_cache;

  localparam int L = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [8:0]  p_address;
  logic        flush;
  logic [31:0] mem_din;
  logic [6:0]  mem_address;
  logic        mem_rd;
  logic [7:0]  dout;
  logic        dv;
  logic        busy;
  logic [7:0]  hit_cnt;
  logic [7:0]  miss_cnt;

  always #5 clk = ~clk;

  dm_read_cache #(.MEM_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .p_address(p_address), .flush(flush),
    .mem_din(mem_din), .mem_address(mem_address), .mem_rd(mem_rd), .dout(dout),
    .dv(dv), .busy(busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // RAM contents and model state
  logic [31:0] mem [128];
  bit          m_valid [8];
  logic [3:0]  m_tag   [8];
  logic [31:0] m_data  [8];
  int          m_busy_end, m_dv_cyc, m_rd_cyc;
  logic [6:0]  m_addr;
  logic [7:0]  m_resp, m_dout_cur, m_hits, m_misses;
  bit          m_pend, m_fill_pend;
  logic [2:0]  m_fill_idx;
  logic [3:0]  m_fill_tag;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] off);
    return 8'(w >> (8 * int'(off)));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    m_busy_end  = -1000;
    m_dv_cyc    = -1000;
    m_rd_cyc    = -1000;
    m_addr      = '0;
    m_resp      = '0;
    m_dout_cur  = '0;
    m_hits      = '0;
    m_misses    = '0;
    m_pend      = 1'b0;
    m_fill_pend = 1'b0;
  endtask

  task automatic compare_outputs();
    check("busy",        32'(busy),        32'(cyc <= m_busy_end));
    check("dv",          32'(dv),          32'(cyc == m_dv_cyc));
    check("mem_rd",      32'(mem_rd),      32'(cyc == m_rd_cyc));
    check("mem_address", 32'(mem_address), 32'(m_addr));
    check("dout",        32'(dout),        32'(m_dout_cur));
    check("hit_cnt",     32'(hit_cnt),     32'(m_hits));
    check("miss_cnt",    32'(miss_cnt),    32'(m_misses));
  endtask

  // Effect of the upcoming clock edge, given the inputs of the current cycle.
  task automatic model_edge();
    bit         idle;
    logic [2:0] idx;
    logic [3:0] tg;
    idle = (cyc > m_busy_end);
    if (m_fill_pend && cyc == m_rd_cyc + L) begin
      m_valid[m_fill_idx] = 1'b1;
      m_tag[m_fill_idx]   = m_fill_tag;
      m_data[m_fill_idx]  = mem[m_addr];
      m_fill_pend         = 1'b0;
    end
    if (!idle) begin
      if (flush) m_pend = 1'b1;
    end else if (flush || m_pend) begin
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      m_pend = 1'b0;
    end else if (req) begin
      idx = p_address[4:2];
      tg  = p_address[8:5];
      if (m_valid[idx] && m_tag[idx] == tg) begin
        if (m_hits != 8'hFF) m_hits++;
        m_resp     = byte_of(m_data[idx], p_address[1:0]);
        m_dv_cyc   = cyc + 1;
        m_busy_end = cyc + 1;
      end else begin
        if (m_misses != 8'hFF) m_misses++;
        m_addr      = p_address[8:2];
        m_resp      = byte_of(mem[p_address[8:2]], p_address[1:0]);
        m_rd_cyc    = cyc + 1;
        m_dv_cyc    = cyc + L + 2;
        m_busy_end  = cyc + L + 2;
        m_fill_pend = 1'b1;
        m_fill_idx  = idx;
        m_fill_tag  = tg;
      end
    end
  endtask

  // One clock cycle: RAM response, full output comparison, new inputs, model.
  task automatic tick(input bit r, input logic [8:0] a, input bit f);
    @(posedge clk);
    #1;
    cyc++;
    mem_din = (cyc == m_rd_cyc + L) ? mem[m_addr] : $urandom();
    if (cyc == m_dv_cyc) m_dout_cur = m_resp;
    compare_outputs();
    req       = r;
    p_address = a;
    flush     = f;
    model_edge();
  endtask

  task automatic wait_dv(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 9'h0, 1'b0);
      if (dv) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_req(input logic [8:0] a, input bit exp_miss,
                        input logic [7:0] exp_byte, input string name);
    int t0;
    int rd_n;
    bit got;
    tick(1'b1, a, 1'b0);
    t0   = cyc;
    rd_n = 0;
    got  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, a, 1'b0);
      if (mem_rd) rd_n++;
      if (dv) begin
        got = 1'b1;
        break;
      end
    end
    check({name, "_dv_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({name, "_latency"}, 32'(cyc - t0), exp_miss ? 32'(L + 2) : 32'd1);
      check({name, "_dout"}, 32'(dout), 32'(exp_byte));
    end
    check({name, "_mem_rd_pulses"}, 32'(rd_n), 32'(exp_miss));
  endtask

  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    req   = 1'b0;
    flush = 1'b0;
    #1;
    model_reset();
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_dv",       32'(dv),       32'd0);
    check("rst_mem_rd",   32'(mem_rd),   32'd0);
    check("rst_hit_cnt",  32'(hit_cnt),  32'd0);
    check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit got;
    int dv_n;
    logic [8:0] a;
    for (int i = 0; i < 128; i++) mem[i] = $urandom();
    mem[5]  = 32'h11223344;
    mem[45] = 32'hAABBCCDD;
    model_reset();
    rst_n = 1'b0; req = 1'b0; flush = 1'b0; p_address = '0; mem_din = '0;
    #3;
    check("init_busy",        32'(busy),        32'd0);
    check("init_dv",          32'(dv),          32'd0);
    check("init_dout",        32'(dout),        32'h00);
    check("init_mem_address", 32'(mem_address), 32'h00);
    check("init_miss_cnt",    32'(miss_cnt),    32'd0);
    #4;
    rst_n = 1'b1;

    // Cold miss, then a hit in the same line
    do_req(9'h014, 1'b1, 8'h44, "miss_014");
    check("miss_cnt_after_first", 32'(miss_cnt), 32'd1);
    check("mem_address_held", 32'(mem_address), 32'h05);
    do_req(9'h015, 1'b0, 8'h33, "hit_015");
    check("hit_cnt_after_hit", 32'(hit_cnt), 32'd1);

    // Conflict: tag 5 evicts tag 0 at index 5 and back again
    do_req(9'h0B4, 1'b1, 8'hDD, "conflict_0B4");
    do_req(9'h014, 1'b1, 8'h44, "refill_014");
    check("miss_cnt_conflict", 32'(miss_cnt), 32'd3);

    // Flush during FILL_WAIT: fill completes, line gone afterwards
    tick(1'b0, 9'h0, 1'b1);
    tick(1'b1, 9'h014, 1'b0);
    tick(1'b0, 9'h014, 1'b0);
    tick(1'b0, 9'h014, 1'b1);
    wait_dv(got);
    check("flush_inflight_dv", 32'(got), 32'd1);
    check("flush_inflight_dout", 32'(dout), 32'h44);
    tick(1'b0, 9'h0, 1'b0);
    do_req(9'h014, 1'b1, 8'h44, "after_flush_014");

    // Flush in IDLE beats a simultaneous request
    tick(1'b1, 9'h014, 1'b1);
    dv_n = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 9'h0, 1'b0);
      if (dv) dv_n++;
    end
    check("flush_drops_req_dv", 32'(dv_n), 32'd0);
    do_req(9'h014, 1'b1, 8'h44, "post_idle_flush_014");

    // Reset mid-fill abandons the fill
    tick(1'b1, 9'h0B4, 1'b0);
    tick(1'b0, 9'h0B4, 1'b0);
    tick(1'b0, 9'h0B4, 1'b0);
    pulse_reset();
    dv_n = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 9'h0, 1'b0);
      if (dv) dv_n++;
    end
    check("reset_fill_no_dv", 32'(dv_n), 32'd0);
    do_req(9'h014, 1'b1, 8'h44, "after_reset_014");
    check("miss_cnt_after_reset", 32'(miss_cnt), 32'd1);

    // Hit counter saturation
    for (int i = 0; i < 260; i++) do_req(9'h014, 1'b0, 8'h44, "sat_hit");
    check("hit_cnt_saturated", 32'(hit_cnt), 32'd255);

    // Request during RESP is ignored
    tick(1'b1, 9'h016, 1'b0);
    tick(1'b1, 9'h016, 1'b0);
    check("resp_dv", 32'(dv), 32'd1);
    check("resp_dout", 32'(dout), 32'h22);
    tick(1'b0, 9'h0, 1'b0);
    check("resp_req_ignored_dv", 32'(dv), 32'd0);
    check("resp_req_ignored_busy", 32'(busy), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      a = {4'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      tick($urandom_range(0, 99) < 40, a, $urandom_range(0, 99) < 3);
      if ($urandom_range(0, 499) == 0) pulse_reset();
    end
    tick(1'b0, 9'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
